// File: rtl/cavlc_scan_ctrl.sv
// Buffers one CAVLC residual block (zig-zag order) and replays it in reverse into the
// trailing-ones counter, then returns a per-block summary word. Optional: CAVLC_ZERO_SKIP_EN.
module cavlc_scan_ctrl #(
    parameter int NUM_COEFF = 16,
    parameter int COEFF_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COEFF_W-1:0] in_coeff,
    output logic               cnt_rst,
    output logic               start_cnt,
    output logic [COEFF_W-1:0] coeff_o,
    input  logic [1:0]         t1s_cnt_i,
    input  logic [2:0]         t1s_flag_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4:0]         total_coeff,
    output logic [3:0]         total_zeros,
    output logic [1:0]         trailing_ones,
    output logic [2:0]         t1_signs
);

    localparam int          IW   = $clog2(NUM_COEFF);
    localparam logic [IW-1:0] LAST = IW'(NUM_COEFF - 1);

    typedef enum logic [2:0] {IDLE, LOAD, CLEAR, SCAN, WAIT, DONE} state_t;

    state_t               state_q, state_d;
    logic [IW-1:0]        ld_idx_q, ld_idx_d;
    logic [IW-1:0]        sc_idx_q, sc_idx_d;
    logic [4:0]           nz_cnt_q, nz_cnt_d;
    logic                 first_nz_q, first_nz_d;
    logic [IW-1:0]        last_pos_q, last_pos_d;
    logic [4:0]           tc_q, tc_d;
    logic [3:0]           tz_q, tz_d;
    logic [1:0]           t1_q, t1_d;
    logic [2:0]           sg_q, sg_d;
    logic                 wr_en;
    logic [IW-1:0]        rd_idx;
    logic [COEFF_W-1:0]   buf_q [NUM_COEFF];
`ifdef CAVLC_ZERO_SKIP_EN
    logic                 all_zero_q, all_zero_d;
`endif

    assign rd_idx = LAST - sc_idx_q;

    always_comb begin
        state_d    = state_q;
        ld_idx_d   = ld_idx_q;
        sc_idx_d   = sc_idx_q;
        nz_cnt_d   = nz_cnt_q;
        first_nz_d = first_nz_q;
        last_pos_d = last_pos_q;
        tc_d       = tc_q;
        tz_d       = tz_q;
        t1_d       = t1_q;
        sg_d       = sg_q;
        wr_en      = 1'b0;
        in_ready   = 1'b0;
        cnt_rst    = 1'b0;
        start_cnt  = 1'b0;
        coeff_o    = '0;
        out_valid  = 1'b0;
`ifdef CAVLC_ZERO_SKIP_EN
        all_zero_d = all_zero_q;
`endif
        case (state_q)
            IDLE, LOAD: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    wr_en    = 1'b1;
                    ld_idx_d = ld_idx_q + IW'(1);
                    state_d  = LOAD;
`ifdef CAVLC_ZERO_SKIP_EN
                    all_zero_d = ((state_q == IDLE) ? 1'b1 : all_zero_q) && (in_coeff == '0);
`endif
                    if (ld_idx_q == LAST) begin
                        ld_idx_d = '0;
                        state_d  = CLEAR;
`ifdef CAVLC_ZERO_SKIP_EN
                        // Empty block: summary is known, leave the counter untouched.
                        if (all_zero_d) begin
                            state_d = DONE;
                            tc_d    = '0;
                            tz_d    = '0;
                            t1_d    = '0;
                            sg_d    = '0;
                        end
`endif
                    end
                end
            end
            CLEAR: begin
                cnt_rst    = 1'b1;
                sc_idx_d   = '0;
                nz_cnt_d   = '0;
                first_nz_d = 1'b0;
                state_d    = SCAN;
            end
            SCAN: begin
                start_cnt = 1'b1;
                coeff_o   = buf_q[rd_idx];
                // First nonzero seen in reverse order is the last one in zig-zag order.
                if (coeff_o != '0) begin
                    nz_cnt_d = nz_cnt_q + 5'd1;
                    if (!first_nz_q) begin
                        first_nz_d = 1'b1;
                        last_pos_d = rd_idx;
                    end
                end
                sc_idx_d = sc_idx_q + IW'(1);
                if (sc_idx_q == LAST) state_d = WAIT;
            end
            WAIT: begin
                t1_d    = t1s_cnt_i;
                sg_d    = t1s_flag_i;
                tc_d    = nz_cnt_q;
                tz_d    = first_nz_q ? 4'(5'(last_pos_q) + 5'd1 - nz_cnt_q) : 4'd0;
                state_d = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ld_idx_q   <= '0;
            sc_idx_q   <= '0;
            nz_cnt_q   <= '0;
            first_nz_q <= 1'b0;
            last_pos_q <= '0;
            tc_q       <= '0;
            tz_q       <= '0;
            t1_q       <= '0;
            sg_q       <= '0;
`ifdef CAVLC_ZERO_SKIP_EN
            all_zero_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ld_idx_q   <= ld_idx_d;
            sc_idx_q   <= sc_idx_d;
            nz_cnt_q   <= nz_cnt_d;
            first_nz_q <= first_nz_d;
            last_pos_q <= last_pos_d;
            tc_q       <= tc_d;
            tz_q       <= tz_d;
            t1_q       <= t1_d;
            sg_q       <= sg_d;
`ifdef CAVLC_ZERO_SKIP_EN
            all_zero_q <= all_zero_d;
`endif
        end
    end

    // Buffer contents are don't-care after reset, so no reset term.
    always_ff @(posedge clk) begin
        if (wr_en) buf_q[ld_idx_q] <= in_coeff;
    end

    assign total_coeff   = tc_q;
    assign total_zeros   = tz_q;
    assign trailing_ones = t1_q;
    assign t1_signs      = sg_q;

endmodule

// File: tb/tb_cavlc_scan_ctrl.sv
// Scoreboard bench for cavlc_scan_ctrl (16-coefficient and 4-coefficient instances) with a
// behavioural trailing-ones counter model closing the loop.
module tb_cavlc_scan_ctrl;

    typedef struct {
        int tc; int tz; int t1; int sg; int scans; int rsts; int lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid = 1'b0, in_ready, cnt_rst, start_cnt, out_valid, out_ready = 1'b1;
    logic [7:0] in_coeff = '0, coeff_o;
    logic [1:0] t1s_cnt, trailing_ones;
    logic [2:0] t1s_flag, t1_signs;
    logic [4:0] total_coeff;
    logic [3:0] total_zeros;

    logic       in_valid4 = 1'b0, in_ready4, cnt_rst4, start_cnt4, out_valid4, out_ready4 = 1'b1;
    logic [7:0] in_coeff4 = '0, coeff_o4;
    logic [1:0] t1s_cnt4, trailing_ones4;
    logic [2:0] t1s_flag4, t1_signs4;
    logic [4:0] total_coeff4;
    logic [3:0] total_zeros4;

    cavlc_scan_ctrl #(.NUM_COEFF(16), .COEFF_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_coeff(in_coeff),
        .cnt_rst(cnt_rst), .start_cnt(start_cnt), .coeff_o(coeff_o),
        .t1s_cnt_i(t1s_cnt), .t1s_flag_i(t1s_flag), .out_valid(out_valid), .out_ready(out_ready),
        .total_coeff(total_coeff), .total_zeros(total_zeros),
        .trailing_ones(trailing_ones), .t1_signs(t1_signs));

    cavlc_scan_ctrl #(.NUM_COEFF(4), .COEFF_W(8)) dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_coeff(in_coeff4),
        .cnt_rst(cnt_rst4), .start_cnt(start_cnt4), .coeff_o(coeff_o4),
        .t1s_cnt_i(t1s_cnt4), .t1s_flag_i(t1s_flag4), .out_valid(out_valid4), .out_ready(out_ready4),
        .total_coeff(total_coeff4), .total_zeros(total_zeros4),
        .trailing_ones(trailing_ones4), .t1_signs(t1_signs4));

    // Trailing-ones counter model: state {stop, cnt[1:0], flag[2:0]}, sign bits shifted in at bit 0.
    function automatic logic [5:0] t1n(input logic [5:0] s, input logic [7:0] c);
        logic [5:0] r;
        r = s;
        if (c != 8'h00 && !s[5]) begin
            if ((c == 8'h01 || c == 8'hFF) && s[4:3] != 2'd3)
                r = {1'b0, s[4:3] + 2'd1, s[1:0], c[7]};
            else
                r[5] = 1'b1;
        end
        return r;
    endfunction

    logic [5:0] m1 = '0, m4 = '0;
    always @(posedge clk) begin
        if (rst || cnt_rst) m1 <= '0;
        else if (start_cnt) m1 <= t1n(m1, coeff_o);
        if (rst || cnt_rst4) m4 <= '0;
        else if (start_cnt4) m4 <= t1n(m4, coeff_o4);
    end
    assign t1s_cnt   = m1[4:3];
    assign t1s_flag  = m1[2:0];
    assign t1s_cnt4  = m4[4:3];
    assign t1s_flag4 = m4[2:0];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t       q[$], q4[$];
    logic [7:0] cq[$], cq4[$];
    int         t0 = 0;
    int         vecs = 0, errs = 0;

    task automatic chk(input string nm, input int act, input int expv);
        vecs++;
        if (act != expv) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, expv, cyc);
        end
    endtask

    // Monitor: all comparisons happen here, on the falling edge.
    int   nscan = 0, nrst = 0;
    logic ov_prev = 1'b0, or_prev = 1'b0;
    int   p_tc, p_tz, p_t1, p_sg;
    always @(negedge clk) begin
        if (rst) begin
            chk("rst in_ready", in_ready, 1);
            chk("rst out_valid", out_valid, 0);
            chk("rst start_cnt", start_cnt, 0);
            chk("rst cnt_rst", cnt_rst, 0);
            chk("rst coeff_o", coeff_o, 0);
            chk("rst summary", {total_coeff, total_zeros, trailing_ones, t1_signs}, 0);
            q.delete(); cq.delete();
            nscan = 0; nrst = 0; ov_prev = 1'b0;
        end else begin
            if (cnt_rst && start_cnt) chk("cnt_rst&start_cnt", 1, 0);
            if (cnt_rst) nrst++;
            if (start_cnt) begin
                nscan++;
                if (cq.size() == 0) chk("unexpected start_cnt", 1, 0);
                else chk("coeff_o", coeff_o, cq.pop_front());
            end
            if (out_valid && !ov_prev && q.size() > 0) chk("latency", cyc - t0, q[0].lat);
            if (out_valid) chk("in_ready in DONE", in_ready, 0);
            if (out_valid && ov_prev && !or_prev)
                chk("stall stable", (total_coeff == p_tc && total_zeros == p_tz &&
                                     trailing_ones == p_t1 && t1_signs == p_sg) ? 1 : 0, 1);
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("unexpected summary", 1, 0);
                else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("total_coeff", total_coeff, e.tc);
                    chk("total_zeros", total_zeros, e.tz);
                    chk("trailing_ones", trailing_ones, e.t1);
                    chk("t1_signs", t1_signs, e.sg);
                    chk("start_cnt cycles", nscan, e.scans);
                    chk("cnt_rst pulses", nrst, e.rsts);
                end
                nscan = 0; nrst = 0;
            end
            ov_prev = out_valid; or_prev = out_ready;
            p_tc = total_coeff; p_tz = total_zeros; p_t1 = trailing_ones; p_sg = t1_signs;

            if (start_cnt4) begin
                if (cq4.size() == 0) chk("dut4 unexpected start_cnt", 1, 0);
                else chk("dut4 coeff_o", coeff_o4, cq4.pop_front());
            end
            if (out_valid4 && out_ready4) begin
                if (q4.size() == 0) chk("dut4 unexpected summary", 1, 0);
                else begin
                    exp_t e;
                    e = q4.pop_front();
                    chk("dut4 total_coeff", total_coeff4, e.tc);
                    chk("dut4 total_zeros", total_zeros4, e.tz);
                    chk("dut4 trailing_ones", trailing_ones4, e.t1);
                end
            end
        end
    end

    logic [7:0] blk [16];

    // Push the hand-computed summary (when summ) and the expected reverse-order scan.
    task automatic push_exp(input bit summ, input int tc, input int tz, input int t1,
                            input int sg, input bit allzero);
        exp_t e;
        bit   skip;
`ifdef CAVLC_ZERO_SKIP_EN
        skip = allzero;
`else
        skip = 1'b0;
`endif
        e.tc = tc; e.tz = tz; e.t1 = t1; e.sg = sg;
        e.scans = skip ? 0 : 16;
        e.rsts  = skip ? 0 : 1;
        e.lat   = skip ? 16 : 34;
        if (summ) q.push_back(e);
        if (!skip) for (int i = 15; i >= 0; i--) cq.push_back(blk[i]);
    endtask

    task automatic drive_block();
        for (int i = 0; i < 16; i++) begin
            int n;
            in_valid = 1'b1;
            in_coeff = blk[i];
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 300) begin
                n++;
                @(negedge clk);
            end
            if (!in_ready) begin
                $display("FAIL in_ready timeout: got 0 expected 1 (beat %0d)", i);
                $fatal(1);
            end
            if (i == 0) t0 = cyc;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || q4.size() != 0) && n < 300) begin
            n++;
            @(posedge clk);
        end
        if (q.size() != 0 || q4.size() != 0) begin
            $display("FAIL summary timeout: got none expected %0d", q.size() + q4.size());
            $fatal(1);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Mixed block with three trailing ones.
        blk = '{8'd0, 8'd3, 8'hFF, 8'd0, 8'd0, 8'hFF, 8'd1, 8'd0, 8'd1,
                8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_exp(1, 5, 4, 3, 3'b001, 0);
        drive_block();
        drain();

        // All-zero block.
        foreach (blk[i]) blk[i] = 8'd0;
        push_exp(1, 0, 0, 0, 0, 1);
        drive_block();
        drain();

        // Sixteen 2s.
        foreach (blk[i]) blk[i] = 8'd2;
        push_exp(1, 16, 0, 0, 0, 0);
        drive_block();
        drain();

        // Back-pressure: hold out_ready low 10 cycles in DONE while the next block waits.
        out_ready = 1'b0;
        blk = '{8'd1, 8'hFF, 8'd0, 8'd0, 8'd3, 8'd0, 8'd0, 8'd0,
                8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_exp(1, 3, 2, 0, 0, 0);
        drive_block();
        blk = '{8'd0, 8'd3, 8'hFF, 8'd0, 8'd0, 8'hFF, 8'd1, 8'd0, 8'd1,
                8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_exp(1, 5, 4, 3, 3'b001, 0);
        fork
            drive_block();
            begin
                int n;
                n = 0;
                while (!out_valid && n < 100) begin
                    n++;
                    @(posedge clk);
                end
                repeat (10) @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        drain();

        // Reset on the 8th SCAN cycle aborts the block.
        push_exp(0, 0, 0, 0, 0, 0);
        drive_block();
        begin
            int n, s;
            n = 0; s = 0;
            while (s < 8 && n < 100) begin
                @(negedge clk);
                n++;
                if (start_cnt) s++;
            end
            #1 rst = 1'b1;
            @(posedge clk);
            @(posedge clk);
            #1 rst = 1'b0;
        end

        // 1,1,1,1 then zeros after the abort.
        foreach (blk[i]) blk[i] = (i < 4) ? 8'd1 : 8'd0;
        push_exp(1, 4, 0, 3, 0, 0);
        drive_block();
        drain();

        // Four-coefficient instance: -1,0,0,5 scans as 5,0,0,-1.
        begin
            exp_t e;
            logic [7:0] b4 [4];
            e.tc = 2; e.tz = 2; e.t1 = 0; e.sg = 0; e.scans = 4; e.rsts = 1; e.lat = 0;
            b4 = '{8'hFF, 8'd0, 8'd0, 8'd5};
            q4.push_back(e);
            for (int i = 3; i >= 0; i--) cq4.push_back(b4[i]);
            for (int i = 0; i < 4; i++) begin
                int n;
                in_valid4 = 1'b1;
                in_coeff4 = b4[i];
                n = 0;
                @(negedge clk);
                while (!in_ready4 && n < 100) begin
                    n++;
                    @(negedge clk);
                end
                @(posedge clk); #1;
            end
            in_valid4 = 1'b0;
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
